// File: rtl/cmp_debounce_if.sv
// Signal bundle between the threshold-crossing debouncer and its environment.
// Ports: en/aeqb/agtb/altb carry the sample enable and comparator flags toward the debouncer;
//        above/rise/fall/err/evt_cnt carry the registered results back out.
interface cmp_debounce_if;
    logic       en;
    logic       aeqb;
    logic       agtb;
    logic       altb;
    logic       above;
    logic       rise;
    logic       fall;
    logic       err;
    logic [7:0] evt_cnt;

    // Side that produces flags and consumes the debounced results.
    modport master (
        output en, aeqb, agtb, altb,
        input  above, rise, fall, err, evt_cnt
    );

    // The debouncer itself.
    modport slave (
        input  en, aeqb, agtb, altb,
        output above, rise, fall, err, evt_cnt
    );
endinterface

// File: rtl/cmp_debounce.sv
// Debounced threshold-crossing detector fed by a magnitude comparator's one-hot flags.
// Latency: a committed change appears one edge after the sample that completes the vote run.
// Backpressure: none; one sample per enabled cycle, en=0 freezes all state.
//
// Ports:
//   clk, rst_n   - single clock, synchronous active-low reset
//   bus (slave)  - en, aeqb, agtb, altb in; above, rise, fall, err, evt_cnt out
// Parameters:
//   DEBOUNCE_CYCLES - consecutive qualifying votes to commit (1 .. 2**CNT_W-1)
//   CNT_W           - vote counter width
// Optional feature: define CMP_DEBOUNCE_EVCNT_EN to build the 8-bit saturating
// rise-event counter on evt_cnt; otherwise evt_cnt is tied to zero.
module cmp_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input logic           clk,
    input logic           rst_n,
    cmp_debounce_if.slave bus
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    logic above_q;
    logic rise_q;
    logic fall_q;
    logic err_q;

    logic above_nxt;
    logic rise_nxt;
    logic fall_nxt;

    logic [2:0] flags;
    logic       one_hot;
    logic       vote_high;
    logic       vote_low;
    logic       bad_sample;

    // ------------------------------------------------------------------
    // Vote decode. Only exactly-one-hot samples vote; anything else is
    // reported and otherwise behaves like a hold, so it can never commit.
    // ------------------------------------------------------------------
    assign flags      = {bus.agtb, bus.altb, bus.aeqb};
    assign one_hot    = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    assign vote_high  = bus.en && (flags == 3'b100);
    assign vote_low   = bus.en && (flags == 3'b010);
    assign bad_sample = bus.en && !one_hot;

    assign cnt_inc = cnt + ONE;

    // ------------------------------------------------------------------
    // Next-state logic. The counter only ever holds the length of the
    // current run of votes opposing the committed level, and is cleared
    // the moment it reaches TARGET, so it cannot exceed TARGET.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            LOW: begin
                if (vote_high) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = PEND_HIGH;
                        cnt_nxt   = ONE;
                    end
                end
            end

            PEND_HIGH: begin
                if (vote_high) begin
                    if (cnt_inc == TARGET) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                        rise_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else if (vote_low) begin
                    // A single opposing vote breaks the run.
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            end

            HIGH: begin
                if (vote_low) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = PEND_LOW;
                        cnt_nxt   = ONE;
                    end
                end
            end

            PEND_LOW: begin
                if (vote_low) begin
                    if (cnt_inc == TARGET) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                        fall_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else if (vote_high) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end
            end

            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase

        // The committed level is a pure function of where the FSM lands;
        // registering it from state_nxt keeps it aligned with rise/fall.
        above_nxt = (state_nxt == HIGH) || (state_nxt == PEND_LOW);
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LOW;
            cnt     <= '0;
            above_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            above_q <= above_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
            err_q   <= bad_sample;
        end
    end

    assign bus.above = above_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.err   = err_q;

    // ------------------------------------------------------------------
    // Optional rise-event counter, saturating at 255.
    // ------------------------------------------------------------------
`ifdef CMP_DEBOUNCE_EVCNT_EN
    logic [7:0] evt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_q <= 8'd0;
        end else if (rise_nxt && (evt_q != 8'hFF)) begin
            evt_q <= evt_q + 8'd1;
        end
    end

    assign bus.evt_cnt = evt_q;
`else
    assign bus.evt_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_cmp_debounce.sv
// Scoreboard bench for cmp_debounce: stimulus pushes expected outputs from a
// level/run-length reference model; a monitor pops and compares every cycle.
module tb_cmp_debounce;

    localparam int D = 4;

    logic clk;
    logic rst_n;

    cmp_debounce_if bus();

    cmp_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       above;
        logic       rise;
        logic       fall;
        logic       err;
        logic [7:0] evt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: committed level, length of the current run of
    // opposing votes, and the number of rises seen.
    bit m_level = 1'b0;
    int m_run   = 0;
    int m_evt   = 0;

    // Apply one cycle of stimulus and record what the DUT must show after
    // the next rising edge.
    task automatic step(input bit r, input bit e, input bit q, input bit g, input bit l);
        exp_t x;
        @(posedge clk);
        #2;
        rst_n    = ~r;
        bus.en   = e;
        bus.aeqb = q;
        bus.agtb = g;
        bus.altb = l;

        x.rise = 1'b0;
        x.fall = 1'b0;
        x.err  = 1'b0;
        if (r) begin
            m_level = 1'b0;
            m_run   = 0;
            m_evt   = 0;
        end else if (e) begin
            if ((int'(q) + int'(g) + int'(l)) != 1) begin
                x.err = 1'b1;
            end else if (!q) begin
                if (g == m_level) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == D) begin
                        m_level = g;
                        m_run   = 0;
                        x.rise  = g;
                        x.fall  = !g;
                        if (g && m_evt < 255) m_evt++;
                    end
                end
            end
        end
        x.above = m_level;
`ifdef CMP_DEBOUNCE_EVCNT_EN
        x.evt = 8'(m_evt);
`else
        x.evt = 8'd0;
`endif
        exp_q.push_back(x);
    endtask

    task automatic hi(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 1, 0);
    endtask

    task automatic lo(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1);
    endtask

    task automatic eq(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0);
    endtask

    // Monitor: outputs are registered, so sample 1 time unit after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus.above !== e.above || bus.rise !== e.rise || bus.fall !== e.fall ||
                bus.err !== e.err || bus.evt_cnt !== e.evt) begin
                miscompares++;
                $display("FAIL outputs vec=%0d t=%0t got above=%b rise=%b fall=%b err=%b evt=%0d want above=%b rise=%b fall=%b err=%b evt=%0d",
                         vectors, $time, bus.above, bus.rise, bus.fall, bus.err, bus.evt_cnt,
                         e.above, e.rise, e.fall, e.err, e.evt);
            end
        end
    end

    initial begin
        int r;
        bit dir;
        bit [2:0] bad;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.aeqb = 1'b0;
        bus.agtb = 1'b0;
        bus.altb = 1'b0;

        // Reset, then a clean debounce to HIGH.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        hi(4);

        // Back to LOW, then a glitch that must not commit.
        lo(4);
        hi(2); lo(1); hi(3);
        lo(1);

        // Holds are transparent to the vote run.
        hi(1); eq(2); hi(3);

        // Fall path interrupted by a disabled stretch.
        lo(2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        lo(2);

        // Illegal flag combinations, including one mid-pending.
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        hi(2);
        step(0, 1, 1, 1, 1);
        hi(2);

        // Reset mid-pending discards the run.
        lo(4);
        hi(3);
        step(1, 1, 0, 1, 0);
        hi(3);
        hi(1);

        // Drive the event counter into saturation.
        for (int i = 0; i < 300; i++) begin
            lo(D);
            hi(D);
        end

        // Randomized flags with sticky direction so transitions do happen.
        dir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 99) < 15) dir = ~dir;
            if (r < 4) begin
                case ($urandom_range(0, 4))
                    0:       bad = 3'b000;
                    1:       bad = 3'b011;
                    2:       bad = 3'b101;
                    3:       bad = 3'b110;
                    default: bad = 3'b111;
                endcase
                step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, bad[2], bad[1], bad[0]);
            end else if (r < 20) begin
                step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, 1, 0, 0);
            end else begin
                step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, 0, dir, !dir);
            end
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmp_debounce.md
# cmp_debounce

Debounced threshold-crossing detector that sits directly downstream of the 4-bit magnitude comparator. It consumes the comparator's one-hot result flags (`aeqb`, `agtb`, `altb`) once per clock. It produces a glitch-free `above` level plus single-cycle `rise`/`fall` pulses, committing a change only after `DEBOUNCE_CYCLES` consecutive qualifying votes. It also flags illegal (non-one-hot) comparator outputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive qualifying votes needed to commit a transition; legal range 1 .. 2^CNT_W-1.
- `CNT_W`, default 4: width of the internal vote counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset; sampled on rising edge of `clk`.
- `en` input 1: sample enable; flags are ignored when low.
- `aeqb` input 1: comparator "a == b" flag; hold vote.
- `agtb` input 1: comparator "a > b" flag; high vote.
- `altb` input 1: comparator "a < b" flag; low vote.
- `above` output 1: debounced level; 1 = a committed above b.
- `rise` output 1: one-cycle pulse on committed 0→1 of `above`.
- `fall` output 1: one-cycle pulse on committed 1→0 of `above`.
- `err` output 1: one-cycle pulse when an enabled sample is not one-hot.
- `evt_cnt` output 8: rise-event count; present only with the macro, otherwise driven 0.

## Operation
- FSM states: LOW, PEND_HIGH, HIGH, PEND_LOW. `above` = 1 in HIGH and PEND_LOW.
- Vote decode applies to enabled cycles only:
  - exactly `agtb` → high vote;
  - exactly `altb` → low vote;
  - exactly `aeqb` → hold;
  - any other combination (none set, or more than one set) → `err` pulse, treated as hold.
- LOW:
  - high vote → counter = 1 and go to PEND_HIGH.
  - If `DEBOUNCE_CYCLES` = 1, go straight to HIGH with `rise`.
- PEND_HIGH:
  - high vote → counter+1; on reaching `DEBOUNCE_CYCLES`, go to HIGH, pulse `rise`, clear counter.
  - low vote → return to LOW, clear counter.
  - hold → counter and state unchanged.
- HIGH and PEND_LOW mirror LOW and PEND_HIGH with votes swapped and `fall` in place of `rise`.
- Votes matching the current committed level (high in HIGH, low in LOW) are no-ops.
- `en` = 0: state, counter and `evt_cnt` frozen; `rise`/`fall`/`err` = 0.
- Counter never exceeds `DEBOUNCE_CYCLES`; no wrap is possible.

## Timing
- Reset values: state LOW, counter 0, `above` 0, `rise` 0, `fall` 0, `err` 0, `evt_cnt` 0.
- Reset has priority over all inputs, including mid-pending; the pending count is discarded.
- All outputs are registered. The flags that complete the N-th qualifying vote at edge k produce `above`/`rise` visible after edge k.
- Latency from the first qualifying sample to `rise` = `DEBOUNCE_CYCLES` enabled, non-hold cycles after that sample's edge, counting that sample as cycle 1.
- `rise`, `fall` and `err` are high for exactly one cycle. `rise` and `fall` are never high together.
- `err` may coincide with nothing else: an erroneous sample cannot commit a transition.
- Inputs must be stable around the `clk` edge; the comparator output is combinational from registered operands.

## Configuration
- `CMP_DEBOUNCE_EVCNT_EN` defined:
  - `evt_cnt` is an 8-bit saturating counter, incremented in the same edge that asserts `rise`.
  - It holds at 255 and resets to 0.
- `CMP_DEBOUNCE_EVCNT_EN` undefined: no counter logic; `evt_cnt` is tied to 8'd0.

## Test plan
- Reset then debounce (`DEBOUNCE_CYCLES`=4): `rst_n`=0 for 2 cycles, then `en`=1 with `agtb`=1 for 4 cycles → `above`=0 for 3 cycles, then `above`=1 and `rise`=1 exactly in cycle 4 only; with macro, `evt_cnt`=1.
- Glitch rejection: in LOW, apply `agtb`,`agtb`,`altb`,`agtb`,`agtb`,`agtb` → no `rise`; state back in LOW after the `altb`; `above` stays 0.
- Hold transparency: `agtb`,`aeqb`,`aeqb`,`agtb`,`agtb`,`agtb` → `rise` on the 6th sample; the `aeqb` cycles neither reset nor advance the counter.
- Fall path and `en` freeze:
  - from HIGH, `altb`×2, then `en`=0 for 5 cycles, then `altb`×2 → `fall` on the last sample;
  - no pulses while `en`=0.
- Illegal flags: `agtb`=`altb`=1 for one cycle, then all-zero for one cycle → `err`=1 both cycles; state and counter unchanged.
- Reset mid-pending and saturation:
  - after 3 high votes, `rst_n`=0 → `above`=0 and counter=0; the next 3 high votes give no `rise`.
  - With macro, 300 rise events → `evt_cnt`=255.
